// File: rtl/branch_resolve_unit_if.sv
// Request/response/lookup bundle for branch_resolve_unit.
//   master: drives the branch request, the result back-pressure and the predictor lookup PC.
//   slave : the resolve unit; returns in_ready, the resolved result, lk_pred and the statistics.
// Request : in_valid, br_mode[2:0], use_imm, rf_a, rf_b, imm, pc, pred_taken -> in_ready
// Result  : out_valid, out_taken, out_mispredict <- out_ready
// Lookup  : lk_pc -> lk_pred
// Stats   : br_cnt, mp_cnt
interface branch_resolve_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 5,
    parameter int unsigned PC_W   = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        br_mode;
    logic              use_imm;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   pc;
    logic              pred_taken;
    logic              out_valid;
    logic              out_ready;
    logic              out_taken;
    logic              out_mispredict;
    logic [PC_W-1:0]   lk_pc;
    logic              lk_pred;
    logic [15:0]       br_cnt;
    logic [15:0]       mp_cnt;

    modport master (
        output in_valid, br_mode, use_imm, rf_a, rf_b, imm, pc, pred_taken, out_ready, lk_pc,
        input  in_ready, out_valid, out_taken, out_mispredict, lk_pred, br_cnt, mp_cnt
    );

    modport slave (
        input  in_valid, br_mode, use_imm, rf_a, rf_b, imm, pc, pred_taken, out_ready, lk_pc,
        output in_ready, out_valid, out_taken, out_mispredict, lk_pred, br_cnt, mp_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares two operands per br_mode, returns the resolved direction and
// whether the frontend mispredicted it one cycle later (valid/ready, single result register),
// trains a table of 2-bit saturating counters and counts resolved/mispredicted branches.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - branch_resolve_unit_if.slave (request, result, predictor lookup, statistics)
// The interface parameters must match DATA_W/IMM_W/PC_W of this module.
module branch_resolve_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned IMM_W     = 5,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned PHT_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_unit_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(PHT_DEPTH);

    typedef enum logic [2:0] {
        ModeNone = 3'b000,
        ModeEq   = 3'b001,
        ModeNe   = 3'b010,
        ModeLt   = 3'b011,
        ModeGe   = 3'b100,
        ModeLtu  = 3'b101,
        ModeGeu  = 3'b110,
        ModeRsvd = 3'b111
    } br_mode_e;

    // Word-aligned index; a PC narrower than the index range zero-extends.
    function automatic logic [IDX_W-1:0] pht_idx(input logic [PC_W-1:0] p);
        return IDX_W'(p >> 2);
    endfunction

    logic [1:0]  pht_q [PHT_DEPTH];
    logic [1:0]  pht_d [PHT_DEPTH];
    logic        out_valid_q, out_valid_d;
    logic        out_taken_q, out_taken_d;
    logic        out_mp_q, out_mp_d;
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] mp_cnt_q, mp_cnt_d;

    logic              in_ready;
    logic              accept;
    logic [DATA_W-1:0] op_b;
    logic              taken;
    logic              mode_valid;
    logic [IDX_W-1:0]  upd_idx;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign upd_idx  = pht_idx(bus.pc);

    // Direction compare
    always_comb begin
        op_b       = bus.use_imm ? DATA_W'(bus.imm) : bus.rf_b;
        taken      = 1'b0;
        mode_valid = 1'b1;
        unique case (br_mode_e'(bus.br_mode))
            ModeEq:   taken = (bus.rf_a == op_b);
            ModeNe:   taken = (bus.rf_a != op_b);
            ModeLt:   taken = ($signed(bus.rf_a) <  $signed(op_b));
            ModeGe:   taken = ($signed(bus.rf_a) >= $signed(op_b));
            ModeLtu:  taken = (bus.rf_a <  op_b);
            ModeGeu:  taken = (bus.rf_a >= op_b);
            ModeNone,
            ModeRsvd: mode_valid = 1'b0;
        endcase
    end

    // Next state
    always_comb begin
        pht_d       = pht_q;
        out_valid_d = out_valid_q;
        out_taken_d = out_taken_q;
        out_mp_d    = out_mp_q;
        br_cnt_d    = br_cnt_q;
        mp_cnt_d    = mp_cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_taken_d = taken;
            out_mp_d    = taken ^ bus.pred_taken;
            if (mode_valid) begin
                if (taken && pht_q[upd_idx] != 2'b11) begin
                    pht_d[upd_idx] = pht_q[upd_idx] + 2'b01;
                end else if (!taken && pht_q[upd_idx] != 2'b00) begin
                    pht_d[upd_idx] = pht_q[upd_idx] - 2'b01;
                end
                if (br_cnt_q != 16'hFFFF) begin
                    br_cnt_d = br_cnt_q + 16'd1;
                end
                if ((taken ^ bus.pred_taken) && mp_cnt_q != 16'hFFFF) begin
                    mp_cnt_d = mp_cnt_q + 16'd1;
                end
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Reset wins over a same-cycle accept and drops any held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_mp_q    <= 1'b0;
            br_cnt_q    <= '0;
            mp_cnt_q    <= '0;
            for (int i = 0; i < int'(PHT_DEPTH); i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_taken_q <= out_taken_d;
            out_mp_q    <= out_mp_d;
            br_cnt_q    <= br_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
            for (int i = 0; i < int'(PHT_DEPTH); i++) begin
                pht_q[i] <= pht_d[i];
            end
        end
    end

    // Lookup reads the registered table, so a same-cycle update returns the old value.
    assign bus.lk_pred        = pht_q[pht_idx(bus.lk_pc)][1];
    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_mispredict = out_mp_q;
    assign bus.br_cnt         = br_cnt_q;
    assign bus.mp_cnt         = mp_cnt_q;
endmodule
